wb_arb2: RTL
============

WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the number of stalled strobe cycles before a bus error is returned (1..65535).
REQ-002 The block SHALL have parameter PRIO_RR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority (master 0 highest).
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset: clk input 1, rising-edge system clock; rst input 1, synchronous active-high reset.
REQ-004 Master ports, N=0,1 (same set per master):
- mN_adr_i input 32: address
- mN_dat_i input 32: write data
- mN_dat_o output 32: read data
- mN_sel_i input 4: byte selects
- mN_we_i input 1: write enable
- mN_cyc_i input 1: cycle request
- mN_stb_i input 1: strobe
- mN_ack_o output 1: acknowledge
- mN_err_o output 1: error
REQ-005 Slave port:
- s_adr_o output 32
- s_dat_o output 32
- s_dat_i input 32
- s_sel_o output 4
- s_we_o output 1
- s_cyc_o output 1
- s_stb_o output 1
- s_ack_i input 1
- s_err_i input 1

Function
REQ-006 The block SHALL implement a registered FSM with states IDLE, GNT0 and GNT1.
REQ-007 In IDLE, the FSM SHALL go to GNTn at the next edge when exactly one mN_cyc_i is high.
REQ-008 In IDLE with both cyc high and PRIO_RR=0, the FSM SHALL go to GNT0.
REQ-009 In IDLE with both cyc high and PRIO_RR=1, the FSM SHALL grant the master not recorded in the last-granted register (last_gnt).
REQ-010 last_gnt SHALL update to n on every IDLE->GNTn transition.
REQ-011 In GNTn, the FSM SHALL stay while mN_cyc_i=1 and return to IDLE at the edge where mN_cyc_i=0, giving one idle bus cycle between ownerships.
REQ-012 Grant latency SHALL be exactly one cycle: cyc high in cycle k gives s_cyc_o high in cycle k+1 (bus free).
REQ-013 In GNTn, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally follow master n's inputs.
REQ-014 In IDLE, s_cyc_o and s_stb_o SHALL be 0 and the other slave outputs SHALL be 0.
REQ-015 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-016 mN_ack_o SHALL equal s_ack_i and mN_err_o SHALL equal (s_err_i | timeout_err) only in GNTn; both SHALL be 0 otherwise.
REQ-017 A non-granted master's cyc/stb SHALL have no effect on slave outputs or on the granted master's transfer.
REQ-018 A 16-bit stall counter SHALL increment each cycle s_stb_o=1 with s_ack_i=0 and s_err_i=0.
REQ-019 The stall counter SHALL clear on ack, on err, when s_stb_o=0, and on state change.
REQ-020 When the stall counter equals TIMEOUT, timeout_err SHALL be 1 for that single cycle, s_stb_o SHALL be forced to 0 that cycle, and the counter SHALL clear.
REQ-021 If s_ack_i and timeout occur in the same cycle, ack SHALL win and timeout_err SHALL remain 0.
REQ-022 If s_ack_i and s_err_i are both high, both SHALL be forwarded unchanged.
REQ-023 A master deasserting cyc mid-burst SHALL release the bus at the next edge regardless of outstanding strobes.

Reset
REQ-024 While rst=1 at a rising edge, the FSM SHALL go to IDLE, last_gnt SHALL become 1 (master 0 wins the first tie under round-robin), and the stall counter SHALL become 0.
REQ-025 During and after reset until a grant, all slave outputs, mN_ack_o and mN_err_o SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL drop s_cyc_o in the cycle after the reset edge and discard any pending ack.

Verification
REQ-027 Single master: m0 read at 0x0000_0100, slave acks after 2 cycles with 0xA5A5A5A5 -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_dat_o=0xA5A5A5A5 with m0_ack_o, m1_ack_o=0.
REQ-028 Round-robin tie: both request continuously with PRIO_RR=1, each cycle of 1 word -> grants alternate m0,m1,m0,m1 with one IDLE cycle between.
REQ-029 Fixed priority: PRIO_RR=0, both request continuously -> m0 gets every grant and m1 is never granted while m0_cyc_i stays high.
REQ-030 Timeout: TIMEOUT=4, slave never acks -> m0_err_o pulses exactly once, 4 cycles after s_stb_o rises, with s_stb_o=0 in that cycle.
REQ-031 Ack-timeout collision: s_ack_i arrives in the TIMEOUT cycle -> m0_ack_o=1 and m0_err_o=0.
REQ-032 Reset mid-transfer: rst pulsed while in GNT1 -> state IDLE, s_cyc_o=0 next cycle, and the next tie is granted to m0.

Source files
------------

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master Wishbone arbiter with round-robin/fixed priority and stall timeout
module wb_arb2 #(
  parameter int TIMEOUT = 255,
  parameter int PRIO_RR = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last_gnt;
  logic [15:0] stall_cnt;
  logic        gnt0;
  logic        gnt1;
  logic        stb_raw;
  logic        timeout_err;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Round-robin hands a tie to whoever did not own the bus last.
          if ((PRIO_RR != 0) && !last_gnt) state_nxt = GNT1;
          else                             state_nxt = GNT0;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stb_raw     = (gnt0 && m0_stb_i) || (gnt1 && m1_stb_i);
  // An ack landing in the timeout cycle completes the transfer normally.
  assign timeout_err = stb_raw && (stall_cnt == TMO) && !s_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT0) last_gnt <= 1'b0;
      if (state == IDLE && state_nxt == GNT1) last_gnt <= 1'b1;
      if ((state_nxt != state) || !stb_raw || s_ack_i || s_err_i || timeout_err)
        stall_cnt <= 16'd0;
      else
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i && !timeout_err;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i && !timeout_err;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = gnt0 && s_ack_i;
  assign m1_ack_o = gnt1 && s_ack_i;
  assign m0_err_o = gnt0 && (s_err_i || timeout_err);
  assign m1_err_o = gnt1 && (s_err_i || timeout_err);

endmodule
